// File: rtl/io_uart_fifo.sv
// Memory-mapped 8N1 UART with TX/RX FIFOs, runtime divisor, sticky error flags and level irq.
// The receive path is built only when IO_UART_RX_EN is defined; otherwise the block is TX-only.
module io_uart_fifo #(
    parameter int unsigned CLK_FREQ_HZ = 10000000,
    parameter int unsigned BAUD_RATE   = 1000000,
    parameter int unsigned TX_DEPTH    = 16,
    parameter int unsigned RX_DEPTH    = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_sel,
    input  logic [1:0]  i_addr,
    input  logic [31:0] i_wdata,
    input  logic        i_wstrb,
    input  logic        i_rstrb,
    output logic [31:0] o_rdata,
    output logic        o_txd,
    input  logic        i_rxd,
    output logic        o_irq
);
    localparam int unsigned TxAw = $clog2(TX_DEPTH);
    localparam int unsigned RxAw = $clog2(RX_DEPTH);
    localparam logic [15:0] DivRst = 16'(CLK_FREQ_HZ / BAUD_RATE - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} uart_state_e;

    logic wr_data, wr_stat, wr_div, rd_data;
    assign wr_data = i_sel && i_wstrb && (i_addr == 2'd0);
    assign wr_stat = i_sel && i_wstrb && (i_addr == 2'd1);
    assign wr_div  = i_sel && i_wstrb && (i_addr == 2'd2);
    assign rd_data = i_sel && i_rstrb && (i_addr == 2'd0);

    // Raw divisor is what software reads back; the shifters use the clamped copy.
    logic [15:0] div_q, div_eff;
    always_ff @(posedge i_clk) begin
        if (i_rst)       div_q <= DivRst;
        else if (wr_div) div_q <= i_wdata[15:0];
    end
    assign div_eff = (div_q < 16'd3) ? 16'd3 : div_q;

    // ---------------- TX FIFO ----------------
    logic [7:0]      tx_mem_q [TX_DEPTH];
    logic [TxAw-1:0] tx_wptr_q, tx_rptr_q;
    logic [TxAw:0]   tx_cnt_q;
    logic            tx_push, tx_pop, tx_full, tx_empty, txovf_set;

    assign tx_full   = tx_cnt_q[TxAw];
    assign tx_empty  = (tx_cnt_q == '0);
    assign tx_push   = wr_data && (!tx_full || tx_pop);
    assign txovf_set = wr_data && tx_full && !tx_pop;

    always_ff @(posedge i_clk) begin
        if (tx_push) tx_mem_q[tx_wptr_q] <= i_wdata[7:0];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tx_wptr_q <= '0;
            tx_rptr_q <= '0;
            tx_cnt_q  <= '0;
        end else begin
            if (tx_push) tx_wptr_q <= tx_wptr_q + TxAw'(1);
            if (tx_pop)  tx_rptr_q <= tx_rptr_q + TxAw'(1);
            if (tx_push && !tx_pop)      tx_cnt_q <= tx_cnt_q + (TxAw+1)'(1);
            else if (!tx_push && tx_pop) tx_cnt_q <= tx_cnt_q - (TxAw+1)'(1);
        end
    end

    // ---------------- TX shifter ----------------
    uart_state_e tx_state_q, tx_state_d;
    logic [15:0] tx_tick_q, tx_tick_d, tx_div_q, tx_div_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic        txd_q, txd_d, tx_end;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tx_state_q <= StIdle;
            tx_tick_q  <= '0;
            tx_div_q   <= DivRst;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            txd_q      <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_tick_q  <= tx_tick_d;
            tx_div_q   <= tx_div_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            txd_q      <= txd_d;
        end
    end

    assign tx_end = (tx_tick_q == tx_div_q);

    always_comb begin
        tx_state_d = tx_state_q;
        tx_tick_d  = tx_tick_q + 16'd1;
        tx_div_d   = tx_div_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        txd_d      = txd_q;
        tx_pop     = 1'b0;
        unique case (tx_state_q)
            StIdle: begin
                txd_d     = 1'b1;
                tx_tick_d = '0;
                if (!tx_empty) begin
                    tx_pop     = 1'b1;
                    tx_state_d = StStart;
                    tx_shift_d = tx_mem_q[tx_rptr_q];
                    tx_div_d   = div_eff;
                    txd_d      = 1'b0;
                end
            end
            StStart: begin
                if (tx_end) begin
                    tx_state_d = StData;
                    tx_tick_d  = '0;
                    tx_bit_d   = '0;
                    tx_div_d   = div_eff;
                    txd_d      = tx_shift_q[0];
                end
            end
            StData: begin
                if (tx_end) begin
                    tx_tick_d = '0;
                    tx_div_d  = div_eff;
                    if (tx_bit_q == 3'd7) begin
                        tx_state_d = StStop;
                        txd_d      = 1'b1;
                    end else begin
                        tx_bit_d   = tx_bit_q + 3'd1;
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        txd_d      = tx_shift_q[1];
                    end
                end
            end
            StStop: begin
                if (tx_end) begin
                    tx_tick_d = '0;
                    if (!tx_empty) begin
                        tx_pop     = 1'b1;
                        tx_state_d = StStart;
                        tx_shift_d = tx_mem_q[tx_rptr_q];
                        tx_div_d   = div_eff;
                        txd_d      = 1'b0;
                    end else begin
                        tx_state_d = StIdle;
                        txd_d      = 1'b1;
                    end
                end
            end
            default: tx_state_d = StIdle;
        endcase
    end

    assign o_txd = txd_q;

    // ---------------- RX path ----------------
    logic       rx_nonempty, rxovr_set, ferr_set, unused_ok;
    logic [7:0] rx_level, rx_byte;

`ifdef IO_UART_RX_EN
    logic [7:0]      rx_mem_q [RX_DEPTH];
    logic [RxAw-1:0] rx_wptr_q, rx_rptr_q;
    logic [RxAw:0]   rx_cnt_q;
    logic            rx_push, rx_wr, rx_pop, rx_full;

    uart_state_e rx_state_q, rx_state_d;
    logic [15:0] rx_tick_q, rx_tick_d, rx_div_q, rx_div_d, rx_half;
    logic [16:0] rx_div_p1;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic        rx_meta_q, rx_sync_q, rx_prev_q;

    assign unused_ok   = ^i_wdata[31:16];
    assign rx_full     = rx_cnt_q[RxAw];
    assign rx_nonempty = (rx_cnt_q != '0);
    assign rx_pop      = rd_data && rx_nonempty;
    assign rx_wr       = rx_push && (!rx_full || rx_pop);
    assign rxovr_set   = rx_push && rx_full && !rx_pop;
    assign rx_level    = 8'(rx_cnt_q);
    assign rx_byte     = rx_mem_q[rx_rptr_q];

    always_ff @(posedge i_clk) begin
        if (rx_wr) rx_mem_q[rx_wptr_q] <= rx_shift_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rx_wptr_q  <= '0;
            rx_rptr_q  <= '0;
            rx_cnt_q   <= '0;
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= StIdle;
            rx_tick_q  <= '0;
            rx_div_q   <= DivRst;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
        end else begin
            if (rx_wr)  rx_wptr_q <= rx_wptr_q + RxAw'(1);
            if (rx_pop) rx_rptr_q <= rx_rptr_q + RxAw'(1);
            if (rx_wr && !rx_pop)      rx_cnt_q <= rx_cnt_q + (RxAw+1)'(1);
            else if (!rx_wr && rx_pop) rx_cnt_q <= rx_cnt_q - (RxAw+1)'(1);
            rx_meta_q  <= i_rxd;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            rx_state_q <= rx_state_d;
            rx_tick_q  <= rx_tick_d;
            rx_div_q   <= rx_div_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
        end
    end

    // Start bit is checked half a bit in so later samples land mid-bit.
    assign rx_div_p1 = {1'b0, rx_div_q} + 17'd1;
    assign rx_half   = rx_div_p1[16:1];

    always_comb begin
        rx_state_d = rx_state_q;
        rx_tick_d  = rx_tick_q + 16'd1;
        rx_div_d   = rx_div_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_push    = 1'b0;
        ferr_set   = 1'b0;
        unique case (rx_state_q)
            StIdle: begin
                rx_tick_d = '0;
                if (rx_prev_q && !rx_sync_q) begin
                    rx_state_d = StStart;
                    rx_div_d   = div_eff;
                end
            end
            StStart: begin
                if (rx_tick_q == rx_half) begin
                    rx_tick_d  = '0;
                    rx_bit_d   = '0;
                    rx_div_d   = div_eff;
                    rx_state_d = rx_sync_q ? StIdle : StData;
                end
            end
            StData: begin
                if (rx_tick_q == rx_div_q) begin
                    rx_tick_d  = '0;
                    rx_div_d   = div_eff;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = StStop;
                end
            end
            StStop: begin
                if (rx_tick_q == rx_div_q) begin
                    rx_tick_d  = '0;
                    rx_state_d = StIdle;
                    rx_push    = rx_sync_q;
                    ferr_set   = !rx_sync_q;
                end
            end
            default: rx_state_d = StIdle;
        endcase
    end
`else
    assign unused_ok   = ^{i_wdata[31:16], i_rxd};
    assign rx_nonempty = 1'b0;
    assign rxovr_set   = 1'b0;
    assign ferr_set    = 1'b0;
    assign rx_level    = '0;
    assign rx_byte     = '0;
`endif

    // ---------------- Flags, status, read port ----------------
    logic [2:0]  flags_q, flags_d, flags_set, flags_clr;
    logic [31:0] status, rdata_q;
    logic        tx_idle;

    assign flags_set = {txovf_set, ferr_set, rxovr_set};
    assign flags_clr = wr_stat ? i_wdata[4:2] : 3'b000;
    assign flags_d   = (flags_q & ~flags_clr) | flags_set;
    assign tx_idle   = tx_empty && (tx_state_q == StIdle);
    assign status    = {rx_level, 8'(tx_cnt_q), 6'b0, tx_full, 4'b0, flags_q, tx_idle,
                        rx_nonempty};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            flags_q <= '0;
            rdata_q <= '0;
        end else begin
            flags_q <= flags_d;
            if (i_sel && i_rstrb) begin
                unique case (i_addr)
                    2'd0:    rdata_q <= rx_nonempty ? {24'b0, rx_byte} : 32'h8000_0000;
                    2'd1:    rdata_q <= status;
                    2'd2:    rdata_q <= {16'b0, div_q};
                    default: rdata_q <= '0;
                endcase
            end
        end
    end

    assign o_rdata = rdata_q;
    assign o_irq   = rx_nonempty || (|flags_q);

endmodule

// File: tb/tb_io_uart_fifo.sv
// Directed bench for io_uart_fifo; RX checks are compiled in only with IO_UART_RX_EN.
module tb_io_uart_fifo;
    logic        i_clk = 1'b0;
    logic        i_rst, i_sel, i_wstrb, i_rstrb, i_rxd;
    logic [1:0]  i_addr;
    logic [31:0] i_wdata, o_rdata;
    logic        o_txd, o_irq;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 i_clk = ~i_clk;

    io_uart_fifo #(
        .CLK_FREQ_HZ(10000000),
        .BAUD_RATE  (1000000),
        .TX_DEPTH   (16),
        .RX_DEPTH   (16)
    ) dut (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_sel  (i_sel),
        .i_addr (i_addr),
        .i_wdata(i_wdata),
        .i_wstrb(i_wstrb),
        .i_rstrb(i_rstrb),
        .o_rdata(o_rdata),
        .o_txd  (o_txd),
        .i_rxd  (i_rxd),
        .o_irq  (o_irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic wr_reg(input logic [1:0] addr, input logic [31:0] data);
        i_sel = 1'b1; i_addr = addr; i_wdata = data; i_wstrb = 1'b1;
        tick(1);
        i_sel = 1'b0; i_wstrb = 1'b0;
    endtask

    task automatic rd_reg(input logic [1:0] addr, output logic [31:0] data);
        i_sel = 1'b1; i_addr = addr; i_rstrb = 1'b1;
        tick(1);
        i_sel = 1'b0; i_rstrb = 1'b0;
        data = o_rdata;
    endtask

    // One frame on i_rxd followed by one idle bit time.
    task automatic send_rx(input logic [7:0] b, input logic stop, input int per);
        i_rxd = 1'b0;
        tick(per);
        for (int i = 0; i < 8; i++) begin
            i_rxd = b[i];
            tick(per);
        end
        i_rxd = stop;
        tick(per);
        i_rxd = 1'b1;
        tick(per);
    endtask

    // Cycles o_txd stays low in the next start bit (bounded).
    task automatic measure_start(output int len);
        int t = 0;
        while (o_txd && t < 50) begin tick(1); t++; end
        len = 0;
        while (!o_txd && len < 50) begin tick(1); len++; end
    endtask

    initial begin
        logic [31:0] rd;
        logic [7:0]  pat;
        int          len;

        i_rst = 1'b1; i_sel = 1'b0; i_addr = 2'd0; i_wdata = '0;
        i_wstrb = 1'b0; i_rstrb = 1'b0; i_rxd = 1'b1;
        tick(3);
        check("rst_txd", 32'(o_txd), 32'd1);
        check("rst_rdata", o_rdata, 32'd0);
        check("rst_irq", 32'(o_irq), 32'd0);
        i_rst = 1'b0;
        tick(1);
        rd_reg(2'd1, rd); check("rst_status", rd, 32'h0000_0002);
        rd_reg(2'd2, rd); check("rst_div", rd, 32'd9);
        rd_reg(2'd0, rd); check("empty_data", rd, 32'h8000_0000);

        // 0x55 at DIV=9: low two cycles after the write, 10-cycle bits
        pat = 8'h55;
        wr_reg(2'd0, 32'h55);
        check("txd_n1", 32'(o_txd), 32'd1);
        tick(1);
        check("txd_n2", 32'(o_txd), 32'd0);
        tick(4);
        check("start_mid", 32'(o_txd), 32'd0);
        for (int k = 0; k < 9; k++) begin
            tick(10);
            check($sformatf("bit%0d", k), 32'(o_txd), (k < 8) ? 32'(pat[k]) : 32'd1);
        end
        tick(6);
        rd_reg(2'd1, rd); check("tx_done_status", rd, 32'h0000_0002);
        check("tx_done_irq", 32'(o_irq), 32'd0);

        // 18 writes: one goes straight to the shifter, 16 fill the FIFO, last is dropped
        for (int i = 0; i < 18; i++) wr_reg(2'd0, 32'h100 | i);
        rd_reg(2'd1, rd); check("full_status", rd, 32'h0010_0210);
        check("txovf_irq", 32'(o_irq), 32'd1);
        wr_reg(2'd1, 32'h0000_FFEF);
        rd_reg(2'd1, rd); check("w1c_other_bits", rd, 32'h0010_0210);
        wr_reg(2'd1, 32'h0000_0010);
        rd_reg(2'd1, rd); check("txovf_clear", rd, 32'h0010_0200);
        check("irq_clear", 32'(o_irq), 32'd0);
        tick(1668);
        rd_reg(2'd1, rd); check("burst_busy", rd, 32'h0000_0000);
        tick(10);
        rd_reg(2'd1, rd); check("burst_idle", rd, 32'h0000_0002);

`ifdef IO_UART_RX_EN
        send_rx(8'hA3, 1'b1, 10);
        rd_reg(2'd1, rd); check("rx_status", rd, 32'h0100_0003);
        check("rx_irq", 32'(o_irq), 32'd1);
        rd_reg(2'd0, rd); check("rx_data", rd, 32'h0000_00A3);
        rd_reg(2'd0, rd); check("rx_empty", rd, 32'h8000_0000);
        check("rx_irq_clear", 32'(o_irq), 32'd0);
        for (int i = 0; i < 17; i++) send_rx(8'(8'h10 + i), 1'b1, 10);
        rd_reg(2'd1, rd); check("rx_ovr", rd, 32'h1000_0007);
        send_rx(8'h5A, 1'b0, 10);
        rd_reg(2'd1, rd); check("rx_ferr", rd, 32'h1000_000F);
        wr_reg(2'd1, 32'h0000_001C);
        rd_reg(2'd1, rd); check("rx_w1c", rd, 32'h1000_0003);
        rd_reg(2'd0, rd); check("rx_first", rd, 32'h0000_0010);
        for (int i = 0; i < 14; i++) rd_reg(2'd0, rd);
        rd_reg(2'd0, rd); check("rx_last", rd, 32'h0000_001F);
        rd_reg(2'd1, rd); check("rx_drained", rd, 32'h0000_0002);
`else
        send_rx(8'hA3, 1'b1, 10);
        rd_reg(2'd1, rd); check("norx_status", rd, 32'h0000_0002);
        check("norx_irq", 32'(o_irq), 32'd0);
        rd_reg(2'd0, rd); check("norx_data", rd, 32'h8000_0000);
`endif

        // Runtime divisor, including the clamp
        wr_reg(2'd2, 32'd4);
        rd_reg(2'd2, rd); check("div4_read", rd, 32'd4);
        wr_reg(2'd0, 32'h55);
        measure_start(len);
        check("div4_period", 32'(len), 32'd5);
        tick(60);
        wr_reg(2'd2, 32'd1);
        rd_reg(2'd2, rd); check("div1_read", rd, 32'd1);
        wr_reg(2'd0, 32'h55);
        measure_start(len);
        check("div1_period", 32'(len), 32'd4);
        tick(50);

        // Reset in the middle of a frame
        wr_reg(2'd0, 32'h00);
        tick(10);
        check("mid_frame_low", 32'(o_txd), 32'd0);
        i_rst = 1'b1;
        tick(1);
        check("rst_mid_txd", 32'(o_txd), 32'd1);
        i_rst = 1'b0;
        rd_reg(2'd1, rd); check("rst_mid_status", rd, 32'h0000_0002);
        rd_reg(2'd2, rd); check("rst_mid_div", rd, 32'd9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
